// File: rtl/noc_params.sv
// noc_params: shared NoC types for routing stages
package noc_params;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  typedef enum logic {XY, YX} route_mode_t;
endpackage

// File: rtl/route_fn.sv
// route_fn: combinational dimension-order route with mesh range check
module route_fn
  import noc_params::*;
#(
  parameter int MESH_SIZE_X = 5,
  parameter int MESH_SIZE_Y = 5,
  localparam int XW = $clog2(MESH_SIZE_X),
  localparam int YW = $clog2(MESH_SIZE_Y)
) (
  input  logic [XW-1:0] x_dest,
  input  logic [YW-1:0] y_dest,
  input  logic [XW-1:0] x_cur,
  input  logic [YW-1:0] y_cur,
  input  route_mode_t   mode,
  output port_t         port,
  output logic          in_range
);
  port_t xp, yp;
  always_comb begin
    xp = x_dest < x_cur ? WEST : x_dest > x_cur ? EAST : LOCAL;
    yp = y_dest < y_cur ? NORTH : y_dest > y_cur ? SOUTH : LOCAL;
    port = mode == XY ? (xp != LOCAL ? xp : yp) : (yp != LOCAL ? yp : xp);
    in_range = 32'(x_dest) < MESH_SIZE_X && 32'(y_dest) < MESH_SIZE_Y;
  end
endmodule

// File: rtl/rc_stage.sv
// rc_stage: registered multi-VC route computation with per-VC hold and error flag
module rc_stage
  import noc_params::*;
#(
  parameter int MESH_SIZE_X = 5,
  parameter int MESH_SIZE_Y = 5,
  parameter int X_CURRENT = MESH_SIZE_X / 2,
  parameter int Y_CURRENT = MESH_SIZE_Y / 2,
  parameter int VC_NUM = 2,
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y),
  localparam int VC_SIZE = $clog2(VC_NUM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        head_valid_i,
  input  logic [VC_SIZE-1:0]          head_vc_i,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  route_mode_t                 mode_i,
  input  logic [VC_NUM-1:0]           release_i,
  output logic [VC_NUM-1:0]           route_valid_o,
  output port_t [VC_NUM-1:0]          out_port_o,
  output logic                        err_o
);
  port_t port;
  logic in_range, vc_ok;
  logic [VC_NUM-1:0] hit, load, viol;
  route_fn #(.MESH_SIZE_X(MESH_SIZE_X), .MESH_SIZE_Y(MESH_SIZE_Y)) u_route (
    .x_dest(x_dest_i),
    .y_dest(y_dest_i),
    .x_cur(DEST_ADDR_SIZE_X'(X_CURRENT)),
    .y_cur(DEST_ADDR_SIZE_Y'(Y_CURRENT)),
    .mode(mode_i),
    .port(port),
    .in_range(in_range)
  );
  // only a non-power-of-two VC count can present an unused VC index
  if ((1 << VC_SIZE) == VC_NUM) begin : g_vc_full
    assign vc_ok = 1'b1;
  end else begin : g_vc_chk
    assign vc_ok = 32'(head_vc_i) < VC_NUM;
  end
  always_comb begin
    hit = '0;
    for (int v = 0; v < VC_NUM; v++) hit[v] = head_valid_i && vc_ok && 32'(head_vc_i) == v;
    load = hit & {VC_NUM{in_range}} & (~route_valid_o | release_i);
    viol = hit & route_valid_o & ~release_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      route_valid_o <= '0;
      err_o <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) out_port_o[v] <= LOCAL;
    end else begin
      route_valid_o <= (route_valid_o & ~release_i) | load;
      err_o <= head_valid_i && (!vc_ok || !in_range || |viol);
      for (int v = 0; v < VC_NUM; v++) if (load[v]) out_port_o[v] <= port;
    end
  end
endmodule
